// File: rtl/ps2_frame_ctrl.sv
// PS/2 keyboard frame receiver: synchronizes kb_clk/kb_data, decodes 11-bit
// frames, folds E0/F0 prefixes into a 16-bit code with valid/ready output.
module ps2_frame_ctrl #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        kb_clk,
    input  logic        kb_data,
    output logic [15:0] code_out,
    output logic        code_valid,
    input  logic        code_ready,
    output logic        error,
    output logic [1:0]  err_type
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [CW-1:0] to_cnt;
    logic          ext_flag;
    logic          brk_flag;

    logic done, frame_err, par_err, timeout;
    logic good, is_e0, is_f0, emit;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], kb_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], kb_data};
            clk_prev  <= clk_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // A falling edge always takes precedence over an expiring timeout.
    always_comb begin
        state_n   = state;
        done      = 1'b0;
        frame_err = 1'b0;
        par_err   = 1'b0;
        timeout   = 1'b0;
        if (fall) begin
            unique case (state)
                IDLE:   if (!data_s) state_n = DATA;
                DATA:   if (bit_cnt == 3'd7) state_n = PARITY;
                PARITY: state_n = STOP;
                STOP: begin
                    state_n = IDLE;
                    done    = 1'b1;
                    if (!data_s)
                        frame_err = 1'b1;
                    else if (!(^{shreg, par_bit}))
                        par_err = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE && to_cnt == TO_LAST) begin
            state_n = IDLE;
            timeout = 1'b1;
        end
    end

    assign good  = done & ~frame_err & ~par_err;
    assign is_e0 = (shreg == 8'hE0);
    assign is_f0 = (shreg == 8'hF0);
    assign emit  = good & ~is_e0 & ~is_f0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            to_cnt  <= '0;
        end else begin
            if (fall && state == IDLE)
                bit_cnt <= '0;
            if (fall && state == DATA) begin
                shreg   <= {data_s, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (fall && state == PARITY)
                par_bit <= data_s;
            if (state == IDLE || fall || timeout)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            code_out   <= '0;
            code_valid <= 1'b0;
            error      <= 1'b0;
            err_type   <= 2'b00;
        end else begin
            error <= 1'b0;
            if (timeout || (done && !good)) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (good) begin
                if (is_e0) begin
                    ext_flag <= 1'b1;
                end else if (is_f0) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                end
            end
            if (frame_err) begin
                error    <= 1'b1;
                err_type <= 2'b10;
            end else if (par_err) begin
                error    <= 1'b1;
                err_type <= 2'b01;
            end else if (timeout) begin
                error    <= 1'b1;
                err_type <= 2'b11;
            end
            // A pending undelivered code is never overwritten.
            if (emit) begin
                if (!code_valid || code_ready) begin
                    code_out   <= {brk_flag, ext_flag, 6'b0, shreg};
                    code_valid <= 1'b1;
                end else begin
                    error    <= 1'b1;
                    err_type <= 2'b00;
                end
            end else if (code_valid && code_ready) begin
                code_valid <= 1'b0;
            end
        end
    end

endmodule
